// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Request/response bundle between one memory master and the data-port
//   arbiter. One instance per master.
//
//   Signals:
//     req    master -> arbiter  access request, level, held until granted
//     we     master -> arbiter  1 = write, 0 = read
//     lock   master -> arbiter  keep ownership after this grant
//     addr   master -> arbiter  access address (AW bits)
//     wdata  master -> arbiter  write data (DW bits)
//     gnt    arbiter -> master  access issued this cycle (combinational)
//     rvalid arbiter -> master  read data valid this cycle
//     rdata  arbiter -> master  read data (DW bits)
//
//   Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Two-master arbiter for the memory data port. Master 0 is the processor
//   data path, master 1 a secondary requester (loader / debug / DMA). At most
//   one access is granted per cycle; the winner's addr/we/wdata drive the
//   memory port combinationally, and read data is routed back to the issuing
//   master one cycle later. A granted master may lock the port for up to
//   LOCK_MAX consecutive cycles; a lock that runs out gives the other master
//   strict priority for the following free cycle.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : round-robin between the masters when both request in FREE
//     undefined : fixed priority, master 0 wins in FREE
//
//   Parameters: AW address width, DW data width, LOCK_MAX max lock cycles (>=1)
//
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous reset, active low
//     m0, m1     master request/response bundles (mem_port_arbiter_if.slave)
//     mem_addr   memory address (0 when nothing is granted)
//     mem_we     memory write enable
//     mem_wdata  memory write data (0 when nothing is granted)
//     mem_rdata  memory read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     m0,
  mem_port_arbiter_if.slave     m1,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_we,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int             CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]  HOLD_LIMIT = CW'(LOCK_MAX);

  typedef enum logic [1:0] {FREE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state, stateNxt;
  logic [CW-1:0] holdCnt, holdCntNxt;
  // One-cycle priority token handed to the other master after a lock expires.
  logic          prioVld, prioVldNxt;
  logic          prioId, prioIdNxt;

  logic          sel;       // id of the master selected this cycle
  logic          gnt0, gnt1, anyGnt;
  logic          selWe, selLock;

  logic          vld_p1;    // read issued last cycle
  logic          tag_p1;    // which master issued it
  logic [DW-1:0] hold0, hold1;
  logic          rvalid0, rvalid1;

`ifdef ARB_ROUND_ROBIN_EN
  logic          lastGnt, lastGntNxt;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FREE;
      holdCnt <= '0;
      prioVld <= 1'b0;
      prioId  <= 1'b0;
    end else begin
      state   <= stateNxt;
      holdCnt <= holdCntNxt;
      prioVld <= prioVldNxt;
      prioId  <= prioIdNxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset points at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lastGnt <= 1'b1;
    else      lastGnt <= lastGntNxt;
  end

  always_comb begin
    lastGntNxt = lastGnt;
    if (anyGnt) lastGntNxt = sel;
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNxt   = state;
    holdCntNxt = holdCnt;
    prioVldNxt = 1'b0;
    prioIdNxt  = prioId;
    case (state)
      OWN0, OWN1: begin
        holdCntNxt = holdCnt + CW'(1);
        if (holdCnt == HOLD_LIMIT) begin
          // Forced release: favour the other master for one free cycle.
          stateNxt   = FREE;
          holdCntNxt = '0;
          prioVldNxt = 1'b1;
          prioIdNxt  = (state == OWN0);
        end else if (!((state == OWN1) ? m1.lock : m0.lock)) begin
          stateNxt   = FREE;
          holdCntNxt = '0;
        end
      end
      default: begin
        holdCntNxt = '0;
        if (anyGnt && selLock) begin
          stateNxt   = sel ? OWN1 : OWN0;
          holdCntNxt = CW'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: selection, grants, memory port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = 1'b0;
    case (state)
      OWN0:    sel = 1'b0;
      OWN1:    sel = 1'b1;
      default: begin
        if (prioVld && (prioId ? m1.req : m0.req)) begin
          sel = prioId;
        end else if (m0.req && m1.req) begin
`ifdef ARB_ROUND_ROBIN_EN
          sel = ~lastGnt;
`else
          sel = 1'b0;
`endif
        end else begin
          sel = !m0.req;
        end
      end
    endcase

    // Grants are forced low while reset is asserted.
    gnt0   = rst && m0.req && !sel;
    gnt1   = rst && m1.req && sel;
    anyGnt = gnt0 || gnt1;

    selWe   = sel ? m1.we   : m0.we;
    selLock = sel ? m1.lock : m0.lock;

    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (anyGnt) begin
      mem_addr  = sel ? m1.addr  : m0.addr;
      mem_we    = selWe;
      mem_wdata = sel ? m1.wdata : m0.wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return stage: issue in p0 (grant cycle), data back in p1
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      tag_p1 <= 1'b0;
      hold0  <= '0;
      hold1  <= '0;
    end else begin
      vld_p1 <= anyGnt && !selWe;
      tag_p1 <= sel;
      if (rvalid0) hold0 <= mem_rdata;
      if (rvalid1) hold1 <= mem_rdata;
    end
  end

  // The tagged master sees mem_rdata directly; the other keeps its last value.
  assign rvalid0 = vld_p1 && !tag_p1;
  assign rvalid1 = vld_p1 && tag_p1;

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rvalid0 ? mem_rdata : hold0;
  assign m1.rdata  = rvalid1 ? mem_rdata : hold1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a small synchronous memory model
//   (one-cycle read latency). Expected values are hand-derived per scenario.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        preload = 1'b1;
  logic [15:0] memAddr, memWdata, memRdata;
  logic        memWe;
  logic [15:0] memArr [0:255];

  int nErrs   = 0;
  int nChecks = 0;

  mem_port_arbiter_if #(.AW(16), .DW(16)) m0If ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) m1If ();

  mem_port_arbiter #(.AW(16), .DW(16), .LOCK_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0If),
    .m1        (m1If),
    .mem_addr  (memAddr),
    .mem_we    (memWe),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: address sampled at the edge, data valid next cycle.
  always @(posedge clk) begin
    if (preload)    memArr[8'h10] <= 16'hBEEF;
    else if (memWe) memArr[memAddr[7:0]] <= memWdata;
    memRdata <= memArr[memAddr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [15:0] addr, input logic [15:0] wdata);
    m0If.req = req; m0If.we = we; m0If.lock = lock; m0If.addr = addr; m0If.wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [15:0] addr, input logic [15:0] wdata);
    m1If.req = req; m1If.we = we; m1If.lock = lock; m1If.addr = addr; m1If.wdata = wdata;
  endtask

  function automatic logic expId(input int i);
`ifdef ARB_ROUND_ROBIN_EN
    return logic'(i % 2);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic p;
    drive0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset: grants held low even with a request present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", m0If.gnt, 0);
    chk("rst_rvalid0", m0If.rvalid, 0);
    chk("rst_rvalid1", m1If.rvalid, 0);
    chk("rst_rdata0", m0If.rdata, 16'h0000);
    chk("rst_memaddr", memAddr, 16'h0000);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    preload = 1'b0;
    rst = 1'b1;

    // Single read by m0.
    drive0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    chk("rd_gnt0", m0If.gnt, 1);
    chk("rd_gnt1", m1If.gnt, 0);
    chk("rd_addr", memAddr, 16'h0010);
    chk("rd_we", memWe, 0);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rd_rvalid0", m0If.rvalid, 1);
    chk("rd_rdata0", m0If.rdata, 16'hBEEF);
    chk("rd_rvalid1", m1If.rvalid, 0);
    chk("idle_addr", memAddr, 16'h0000);
    chk("idle_wdata", memWdata, 16'h0000);
    tick();
    @(negedge clk);
    chk("rd_rvalid0_off", m0If.rvalid, 0);
    chk("rd_rdata0_hold", m0If.rdata, 16'hBEEF);

    // m1 write then read.
    tick();
    drive1(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234);
    @(negedge clk);
    chk("wr_gnt1", m1If.gnt, 1);
    chk("wr_we", memWe, 1);
    chk("wr_addr", memAddr, 16'h0020);
    chk("wr_wdata", memWdata, 16'h1234);
    tick();
    drive1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    chk("wr_no_rvalid", m1If.rvalid, 0);
    chk("wr_rd_gnt1", m1If.gnt, 1);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("wr_rvalid1", m1If.rvalid, 1);
    chk("wr_rdata1", m1If.rdata, 16'h1234);
    chk("wr_rvalid0", m0If.rvalid, 0);
    chk("wr_rdata0_hold", m0If.rdata, 16'hBEEF);

    // Contention: both read for 4 cycles.
    tick();
    drive0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("ct_gnt0_%0d", i), m0If.gnt, !expId(i));
        chk($sformatf("ct_gnt1_%0d", i), m1If.gnt, expId(i));
      end
      if (i > 0) begin
        p = expId(i - 1);
        chk($sformatf("ct_rv0_%0d", i), m0If.rvalid, !p);
        chk($sformatf("ct_rv1_%0d", i), m1If.rvalid, p);
        if (p) chk($sformatf("ct_rd1_%0d", i), m1If.rdata, 16'h1234);
        else   chk($sformatf("ct_rd0_%0d", i), m0If.rdata, 16'hBEEF);
      end
      tick();
    end

    // Lock hold: m0 locks 12 cycles, m1 requests throughout.
    drive0(1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("lk_gnt0_%0d", i), m0If.gnt, (i != 9));
      chk($sformatf("lk_gnt1_%0d", i), m1If.gnt, (i == 9));
      tick();
    end
    drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();

    // Lock release after 3 cycles; m1 granted on the first free cycle.
    drive0(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    tick();
    drive1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    for (int i = 1; i < 4; i++) begin
      if (i == 3) m0If.lock = 1'b0;
      @(negedge clk);
      chk($sformatf("rl_gnt0_%0d", i), m0If.gnt, 1);
      chk($sformatf("rl_gnt1_%0d", i), m1If.gnt, 0);
      tick();
    end
    drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rl_gnt1_free", m1If.gnt, 1);
    chk("rl_gnt0_free", m0If.gnt, 0);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rl_rvalid1", m1If.rvalid, 1);
    chk("rl_rdata1", m1If.rdata, 16'h1234);
    tick();

    // Async reset mid-lock with a read in flight.
    drive0(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    tick();
    tick();
    chk("ar_rvalid0_pre", m0If.rvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_gnt0", m0If.gnt, 0);
    chk("ar_rvalid0", m0If.rvalid, 0);
    chk("ar_rdata0", m0If.rdata, 16'h0000);
    drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    rst = 1'b1;
    drive0(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    chk("ar_rvalid0_drop", m0If.rvalid, 0);
    chk("ar_tie_gnt0", m0If.gnt, 1);
    chk("ar_tie_gnt1", m1If.gnt, 0);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("ar_free_gnt1", m1If.gnt, 1);
    chk("ar_rvalid0_post", m0If.rvalid, 1);
    chk("ar_rdata0_post", m0If.rdata, 16'hBEEF);
    tick();
    drive1(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
